spi_mem_slave: RTL and testbench

SPI_MEM_SLAVE -- requirements
Module: spi_mem_slave

---
 rtl/spi_mem_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_mem_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_slave.sv
// rtl/spi_mem_slave.sv - SPI slave giving command-framed burst read/write access to an on-chip word memory
module spi_mem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic wr_strobe,
  output logic frame_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miso_q, miso_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              frame_done_q, frame_done_d;
  logic              ld1_q, ld1_d;
  logic              ld2_q, ld2_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic              sample_edge, shift_edge, cs_fall;
  logic [DATA_W-1:0] rx_word;
  logic              wr_en;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    miso_d       = miso_q;
    wr_strobe_d  = 1'b0;
    frame_done_d = 1'b0;
    ld1_d        = 1'b0;
    ld2_d        = ld1_q;
    wr_en        = 1'b0;
    rx_word      = {shreg_q, mosi_s};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      CMD, WRITE, READ: begin
        if (sample_edge) begin
          shreg_d   = rx_word[DATA_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (state_q == CMD) begin
              addr_d  = rx_word[ADDR_W-1:0];
              state_d = rx_word[DATA_W-1] ? READ : WRITE;
              ld1_d   = rx_word[DATA_W-1];
              miso_d  = 1'b0;
            end else begin
              addr_d      = addr_q + ADDR_W'(1);
              wr_en       = (state_q == WRITE);
              wr_strobe_d = (state_q == WRITE);
              ld1_d       = (state_q == READ);
            end
          end
        end
        // The RAM has one cycle of latency after addr_q settles, so the
        // transmit load lands two cycles after the word boundary.
        if (state_q == READ) begin
          if (ld2_q) begin
            if (CPHA) begin
              tx_d = rd_data_q;
            end else begin
              miso_d = rd_data_q[DATA_W-1];
              tx_d   = {rd_data_q[DATA_W-2:0], 1'b0};
            end
          end else if (shift_edge && (CPHA || (bit_cnt_q != '0))) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        // A sample edge seen in the same cycle is still honoured above.
        if (cs_s) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          miso_d       = 1'b0;
          ld1_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q  <= {SYNC_STAGES{CPOL}};
      cs_sync_q    <= {SYNC_STAGES{1'b1}};
      mosi_sync_q  <= '0;
      sclk_prev_q  <= CPOL;
      cs_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      miso_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      frame_done_q <= 1'b0;
      ld1_q        <= 1'b0;
      ld2_q        <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      miso_q       <= miso_d;
      wr_strobe_q  <= wr_strobe_d;
      frame_done_q <= frame_done_d;
      ld1_q        <= ld1_d;
      ld2_q        <= ld2_d;
    end
  end

  // Contents survive reset; a reset mid-frame forces IDLE so wr_en stays low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_q] <= rx_word;
    end
    rd_data_q <= mem[addr_q];
  end

  assign busy       = (state_q != IDLE);
  assign miso_oe    = (state_q == READ);
  assign miso       = miso_q & miso_oe;
  assign wr_strobe  = wr_strobe_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb/tb_spi_mem_slave.sv - self-checking bench for spi_mem_slave in SPI modes 0 and 3
module tb_spi_mem_slave;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sclk_v, cs_n_v, mosi_v, miso_v, oe_v, busy_v, wrs_v, fd_v;

  int total = 0;
  int bad = 0;
  int wr_cnt [2] = '{0, 0};
  int fd_cnt [2] = '{0, 0};
  int oe_bad [2] = '{0, 0};

  logic [7:0] model_mem [2][128];
  bit         known [2][128];

  typedef struct {
    int          m;
    int          n;
    logic [63:0] tx;
    logic [63:0] exp_rx;
    int          exp_wr;
    string       name;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  spi_mem_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_mode0 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk_v[0]), .cs_n(cs_n_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .busy(busy_v[0]), .wr_strobe(wrs_v[0]),
    .frame_done(fd_v[0])
  );

  spi_mem_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(3)) u_mode3 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk_v[1]), .cs_n(cs_n_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .busy(busy_v[1]), .wr_strobe(wrs_v[1]),
    .frame_done(fd_v[1])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wrs_v[i]) wr_cnt[i]++;
      if (fd_v[i]) fd_cnt[i]++;
      if (!oe_v[i] && miso_v[i]) oe_bad[i]++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master side: mode 0 drives before the leading edge, mode 3 after it;
  // miso is captured just before each sample edge.
  task automatic spi_bits(input int m, input logic [63:0] tx, input int n,
                          output logic [63:0] rx, output logic [63:0] oe);
    rx = '0;
    oe = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (m == 0) begin
        mosi_v[m] = tx[i];
        repeat (H) @(negedge clk);
        rx[i] = miso_v[m];
        oe[i] = oe_v[m];
        sclk_v[m] = ~sclk_v[m];
        repeat (H) @(negedge clk);
        sclk_v[m] = ~sclk_v[m];
      end else begin
        sclk_v[m] = ~sclk_v[m];
        mosi_v[m] = tx[i];
        repeat (H) @(negedge clk);
        rx[i] = miso_v[m];
        oe[i] = oe_v[m];
        sclk_v[m] = ~sclk_v[m];
        repeat (H) @(negedge clk);
      end
    end
  endtask

  function automatic void model_write(input int m, input logic [63:0] tx, input int n);
    logic [6:0] a;
    int         k;
    if (n < 8 || tx[n-1]) return;
    a = tx[n-2 -: 7];
    k = (n - 8) / 8;
    for (int j = 0; j < k; j++) begin
      model_mem[m][a] = tx[n-9-8*j -: 8];
      known[m][a] = 1'b1;
      a = a + 7'd1;
    end
  endfunction

  function automatic void model_expect(input int m, input logic [63:0] tx, input int n,
                                       output logic [63:0] exp, output logic [63:0] mask);
    logic [6:0] a;
    int         k, part, pos;
    exp  = '0;
    mask = (64'd1 << n) - 64'd1;
    if (n >= 8 && tx[n-1]) begin
      a    = tx[n-2 -: 7];
      k    = (n - 8) / 8;
      part = n - 8 - 8 * k;
      mask = mask & ~((64'd1 << part) - 64'd1);
      for (int j = 0; j < k; j++) begin
        pos = n - 9 - 8 * j;
        if (known[m][a]) exp[pos -: 8] = model_mem[m][a];
        else mask[pos -: 8] = 8'h00;
        a = a + 7'd1;
      end
    end
  endfunction

  task automatic do_frame(input int m, input logic [63:0] tx, input int n, input logic [63:0] exp_rx,
                          input logic [63:0] mask, input int exp_wr, input string name);
    logic [63:0] rx, oe, exp_oe;
    logic        busy_mid;
    int          wr0, fd0;
    wr0 = wr_cnt[m];
    fd0 = fd_cnt[m];
    cs_n_v[m] = 1'b0;
    repeat (H) @(negedge clk);
    busy_mid = busy_v[m];
    spi_bits(m, tx, n, rx, oe);
    repeat (H) @(negedge clk);
    cs_n_v[m] = 1'b1;
    repeat (3 * H) @(negedge clk);
    exp_oe = (n > 8 && tx[n-1]) ? ((64'd1 << (n - 8)) - 64'd1) : 64'd0;
    check({name, ":rx"}, rx & mask, exp_rx & mask);
    check({name, ":oe"}, oe, exp_oe);
    check({name, ":wr"}, 64'(wr_cnt[m] - wr0), 64'(exp_wr));
    check({name, ":fd"}, 64'(fd_cnt[m] - fd0), 64'd1);
    check({name, ":busy_mid"}, 64'(busy_mid), 64'd1);
    check({name, ":busy_end"}, 64'(busy_v[m]), 64'd0);
    model_write(m, tx, n);
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rx, oe, tx, exp, mask;
    int          m, n, k, part, rd, addr, wr0, fd0;

    sclk_v  = 2'b10;
    cs_n_v  = 2'b11;
    mosi_v  = 2'b00;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_m0", {miso_v[0], oe_v[0], busy_v[0], wrs_v[0], fd_v[0]}, 64'd0);
    check("reset_m3", {miso_v[1], oe_v[1], busy_v[1], wrs_v[1], fd_v[1]}, 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int mm = 0; mm < 2; mm++) begin
      tbl.push_back('{mm, 16, 64'h10A5,   64'h0,      1, "wr_10_a5"});
      tbl.push_back('{mm, 16, 64'h9000,   64'h00A5,   0, "rd_90"});
      tbl.push_back('{mm, 24, 64'h7F1122, 64'h0,      2, "burst_wr_7f"});
      tbl.push_back('{mm, 24, 64'hFF0000, 64'h001122, 0, "burst_rd_wrap"});
      tbl.push_back('{mm, 16, 64'h053C,   64'h0,      1, "wr_05_3c"});
      tbl.push_back('{mm, 13, 64'h00B8,   64'h0,      0, "abort_05"});
      tbl.push_back('{mm, 16, 64'h8500,   64'h003C,   0, "rd_05"});
      tbl.push_back('{mm, 5,  64'h0015,   64'h0,      0, "short_cmd"});
    end
    foreach (tbl[i]) begin
      do_frame(tbl[i].m, tbl[i].tx, tbl[i].n, tbl[i].exp_rx, (64'd1 << tbl[i].n) - 64'd1,
               tbl[i].exp_wr, $sformatf("m%0d_%s", tbl[i].m * 3, tbl[i].name));
    end

    // Last sample edge of a data word coincides with cs_n rising.
    wr0 = wr_cnt[0];
    fd0 = fd_cnt[0];
    cs_n_v[0] = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(0, {8'h30, 7'b1100110}, 15, rx, oe);
    mosi_v[0] = 1'b1;
    repeat (H) @(negedge clk);
    sclk_v[0] = 1'b1;
    cs_n_v[0] = 1'b1;
    repeat (2 * H) @(negedge clk);
    sclk_v[0] = 1'b0;
    repeat (3 * H) @(negedge clk);
    check("simul:wr", 64'(wr_cnt[0] - wr0), 64'd1);
    check("simul:fd", 64'(fd_cnt[0] - fd0), 64'd1);
    check("simul:busy", 64'(busy_v[0]), 64'd0);
    model_write(0, 64'h30CD, 16);
    do_frame(0, 64'hB000, 16, 64'h00CD, 64'hFFFF, 0, "simul_rd_30");

    // Reset asserted in the middle of a data word.
    do_frame(0, 64'h2077, 16, 64'h0, 64'hFFFF, 1, "wr_20_77");
    wr0 = wr_cnt[0];
    cs_n_v[0] = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(0, {8'h20, 4'b1001}, 12, rx, oe);
    check("pre_reset:busy", 64'(busy_v[0]), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset:outs", {miso_v[0], oe_v[0], busy_v[0], wrs_v[0], fd_v[0]}, 64'd0);
    cs_n_v[0] = 1'b1;
    repeat (4 * H) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    check("mid_reset:wr", 64'(wr_cnt[0] - wr0), 64'd0);
    do_frame(0, 64'hA000, 16, 64'h0077, 64'hFFFF, 0, "post_reset_rd_20");
    do_frame(0, 64'h205A, 16, 64'h0, 64'hFFFF, 1, "post_reset_wr_20");
    do_frame(0, 64'hA000, 16, 64'h005A, 64'hFFFF, 0, "post_reset_rd2_20");

    for (int it = 0; it < 30; it++) begin
      m    = $urandom_range(0, 1);
      rd   = (it < 8) ? 0 : $urandom_range(0, 1);
      addr = $urandom_range(0, 1) ? $urandom_range(0, 11) : $urandom_range(122, 127);
      k    = $urandom_range(1, 5);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      n    = 8 + 8 * k + part;
      tx   = 64'(rd * 128 + addr);
      for (int j = 0; j < k; j++) tx = (tx << 8) | 64'($urandom_range(0, 255));
      tx = (tx << part) | 64'($urandom_range(0, (1 << part) - 1));
      model_expect(m, tx, n, exp, mask);
      do_frame(m, tx, n, exp, mask, rd ? 0 : k, $sformatf("rand%0d_m%0d", it, m * 3));
    end

    check("oe_low_miso_m0", 64'(oe_bad[0]), 64'd0);
    check("oe_low_miso_m3", 64'(oe_bad[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
